// File: rtl/request_sampler_nch.sv
// Request sampler: per-channel synchroniser, edge latch or level filter, enable masking,
// and a registered lowest-index priority encoder feeding the sequencer.
`default_nettype none

module request_sampler_nch #(
    parameter int             NCH         = 4,
    parameter int             SYNC_STAGES = 2,
    parameter logic [NCH-1:0] EDGE_MODE   = 4'b0010,
    parameter logic [NCH-1:0] NOMASK      = 4'b0010,
    parameter int             FILTER      = 2,
    localparam int            IDW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [NCH-1:0] Req,
    input  logic [NCH-1:0] Enable,
    input  logic           Ack,
    input  logic [IDW-1:0] AckId,
    input  logic           ClearAll,
    output logic [NCH-1:0] Pending,
    output logic           Valid,
    output logic [IDW-1:0] Id
);

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] hist_q;
    logic [NCH-1:0] pend_q, pend_d;
    logic [3:0]     cnt_q [NCH];
    logic [3:0]     cnt_d [NCH];
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;

    logic [NCH-1:0] s_w, rise_w, ack_hit_w, elig_w;

    always_comb begin
        s_w    = sync_q[SYNC_STAGES-1];
        rise_w = s_w & ~hist_q;
        elig_w = pend_q & (Enable | NOMASK);
        for (int i = 0; i < NCH; i++) begin
            // An AckId outside 0..NCH-1 can never equal a channel index, so it is ignored.
            ack_hit_w[i] = Ack && (int'(AckId) == i);
            if (EDGE_MODE[i]) begin
                cnt_d[i]  = 4'd0;
                pend_d[i] = ~ClearAll & (rise_w[i] | (pend_q[i] & ~ack_hit_w[i]));
            end else begin
                if (ClearAll || !s_w[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] == 4'(FILTER)) begin
                    cnt_d[i] = cnt_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
                // Compare the next count so Pending rises on the same edge the filter saturates.
                pend_d[i] = (cnt_d[i] == 4'(FILTER));
            end
        end
        valid_d = |elig_w;
        id_d    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig_w[i]) begin
                id_d = IDW'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= 4'd0;
            end
            hist_q  <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            sync_q[0] <= Req;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            hist_q  <= s_w;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign Pending = pend_q;
    assign Valid   = valid_q;
    assign Id      = id_q;

endmodule

`default_nettype wire
